// File: rtl/regfile_stack_ctx_ctrl_if.sv
// Sequencer-side bundle between the interrupt arbiter/CSR unit and regfile_stack_ctx_ctrl.
// Command encoding on o_command: 0 = none, 1 = push, 2 = pop.
interface regfile_stack_ctx_ctrl_if #(
   parameter int DEPTH  = 4,
   parameter int PRIO_W = 3
);
   localparam int DEPTH_W = $clog2(DEPTH + 1);

   logic                i_irq_valid;
   logic [PRIO_W-1:0]   i_irq_prio;
   logic                i_mret;
   logic                i_stall;
   logic [1:0]          o_command;
   logic                o_irq_ack;
   logic [DEPTH_W-1:0]  o_depth;
   logic [PRIO_W-1:0]   o_cur_prio;
   logic                o_error;

   modport master (
      output i_irq_valid, i_irq_prio, i_mret, i_stall,
      input  o_command, o_irq_ack, o_depth, o_cur_prio, o_error
   );

   modport slave (
      input  i_irq_valid, i_irq_prio, i_mret, i_stall,
      output o_command, o_irq_ack, o_depth, o_cur_prio, o_error
   );
endinterface

// File: rtl/regfile_stack_ctx_ctrl.sv
// Context-switch sequencer for the stacked register file: push on interrupt entry, pop on mret.
// Optional tail-chaining on mret is enabled by defining HIPPO_STACK_TAILCHAIN_EN.
module regfile_stack_ctx_ctrl #(
   parameter int DEPTH  = 4,
   parameter int PRIO_W = 3
) (
   input logic                     i_clk,
   input logic                     i_reset,
   regfile_stack_ctx_ctrl_if.slave bus
);
   localparam int         DEPTH_W = $clog2(DEPTH + 1);
   localparam logic [1:0] CMD_NONE = 2'd0;
   localparam logic [1:0] CMD_PUSH = 2'd1;
   localparam logic [1:0] CMD_POP  = 2'd2;

   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [PRIO_W-1:0]  prio_q [DEPTH];
   logic [PRIO_W-1:0]  prio_d [DEPTH];
   logic               error_q, error_d;
   logic [PRIO_W-1:0]  cur_prio;
   logic               chain, ret, accept, mret_live;
   logic [1:0]         command;
   logic               irq_ack;

   always_comb begin
      cur_prio = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (depth_q == DEPTH_W'(i + 1)) cur_prio = prio_q[i];
      end
   end

`ifdef HIPPO_STACK_TAILCHAIN_EN
   // Priority of the context that an mret would resume; 0 means thread level.
   logic [PRIO_W-1:0] below;
   always_comb begin
      below = '0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (depth_q == DEPTH_W'(i + 2)) below = prio_q[i];
      end
   end
   assign chain = bus.i_mret && bus.i_irq_valid && !bus.i_stall &&
                  (depth_q != '0) && (bus.i_irq_prio > below);
`else
   assign chain = 1'b0;
`endif

   assign mret_live = bus.i_mret && !bus.i_stall;
   assign ret       = mret_live && (depth_q != '0);
   assign accept    = bus.i_irq_valid && !bus.i_stall && !bus.i_mret &&
                      (bus.i_irq_prio > cur_prio) && (depth_q < DEPTH_W'(DEPTH));

   always_comb begin
      depth_d = depth_q;
      prio_d  = prio_q;
      error_d = error_q;
      command = CMD_NONE;
      irq_ack = 1'b0;
      if (chain) begin
         irq_ack = 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == DEPTH_W'(i + 1)) prio_d[i] = bus.i_irq_prio;
         end
      end else if (ret) begin
         command = CMD_POP;
         depth_d = depth_q - DEPTH_W'(1);
      end else if (accept) begin
         command = CMD_PUSH;
         irq_ack = 1'b1;
         depth_d = depth_q + DEPTH_W'(1);
         for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == DEPTH_W'(i)) prio_d[i] = bus.i_irq_prio;
         end
      end
      if (mret_live && (depth_q == '0)) error_d = 1'b1;
      // The regfile resets on the same edge, so nothing may be issued this cycle.
      if (i_reset) begin
         command = CMD_NONE;
         irq_ack = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         depth_q <= '0;
         error_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) prio_q[i] <= '0;
      end else begin
         depth_q <= depth_d;
         error_q <= error_d;
         prio_q  <= prio_d;
      end
   end

   assign bus.o_command  = command;
   assign bus.o_irq_ack  = irq_ack;
   assign bus.o_depth    = depth_q;
   assign bus.o_cur_prio = cur_prio;
   assign bus.o_error    = error_q;
endmodule

// File: tb/tb_regfile_stack_ctx_ctrl.sv
// Directed bench for regfile_stack_ctx_ctrl (DEPTH=4, PRIO_W=3); honours HIPPO_STACK_TAILCHAIN_EN.
module tb_regfile_stack_ctx_ctrl;
   localparam logic [1:0] CMD_NONE = 2'd0;
   localparam logic [1:0] CMD_PUSH = 2'd1;
   localparam logic [1:0] CMD_POP  = 2'd2;

   logic i_clk = 1'b0;
   logic i_reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   regfile_stack_ctx_ctrl_if #(.DEPTH(4), .PRIO_W(3)) bus ();

   regfile_stack_ctx_ctrl #(.DEPTH(4), .PRIO_W(3)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] p, input logic m, input logic s);
      bus.i_irq_valid = v;
      bus.i_irq_prio  = p;
      bus.i_mret      = m;
      bus.i_stall     = s;
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 3'd0, 1'b0, 1'b0);
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      drive(1'b1, 3'd5, 1'b0, 1'b0);
      n_cmp++; if (bus.o_command !== CMD_NONE) begin n_bad++; $display("FAIL reset_cmd: got %0d expected %0d", bus.o_command, CMD_NONE); end
      n_cmp++; if (bus.o_irq_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %0b expected 0", bus.o_irq_ack); end
      tick();
      i_reset = 1'b0;
      drive(1'b0, 3'd0, 1'b0, 1'b0);
      n_cmp++; if (bus.o_depth !== 3'd0) begin n_bad++; $display("FAIL reset_depth: got %0d expected 0", bus.o_depth); end
      n_cmp++; if (bus.o_cur_prio !== 3'd0) begin n_bad++; $display("FAIL reset_prio: got %0d expected 0", bus.o_cur_prio); end
      n_cmp++; if (bus.o_error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %0b expected 0", bus.o_error); end
   endtask

   task automatic test_nest_full();
      logic [1:0] exp_cmd;
      logic       exp_ack;
      logic [2:0] exp_depth, exp_prio;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 3'(2 + k), 1'b0, 1'b0);
         exp_cmd   = (k < 4) ? CMD_PUSH : CMD_NONE;
         exp_ack   = (k < 4);
         exp_depth = (k < 4) ? 3'(k + 1) : 3'd4;
         exp_prio  = (k < 4) ? 3'(k + 2) : 3'd5;
         n_cmp++; if (bus.o_command !== exp_cmd) begin n_bad++; $display("FAIL nest_cmd[%0d]: got %0d expected %0d", k, bus.o_command, exp_cmd); end
         n_cmp++; if (bus.o_irq_ack !== exp_ack) begin n_bad++; $display("FAIL nest_ack[%0d]: got %0b expected %0b", k, bus.o_irq_ack, exp_ack); end
         tick();
         n_cmp++; if (bus.o_depth !== exp_depth) begin n_bad++; $display("FAIL nest_depth[%0d]: got %0d expected %0d", k, bus.o_depth, exp_depth); end
         n_cmp++; if (bus.o_cur_prio !== exp_prio) begin n_bad++; $display("FAIL nest_prio[%0d]: got %0d expected %0d", k, bus.o_cur_prio, exp_prio); end
      end
      drive(1'b0, 3'd0, 1'b0, 1'b0);
   endtask

   task automatic test_prio_filter();
      do_reset();
      drive(1'b1, 3'd3, 1'b0, 1'b0);
      tick();
      drive(1'b1, 3'd3, 1'b0, 1'b0);
      n_cmp++; if (bus.o_irq_ack !== 1'b0) begin n_bad++; $display("FAIL filter_eq_ack: got %0b expected 0", bus.o_irq_ack); end
      n_cmp++; if (bus.o_command !== CMD_NONE) begin n_bad++; $display("FAIL filter_eq_cmd: got %0d expected %0d", bus.o_command, CMD_NONE); end
      tick();
      n_cmp++; if (bus.o_depth !== 3'd1) begin n_bad++; $display("FAIL filter_eq_depth: got %0d expected 1", bus.o_depth); end
      drive(1'b1, 3'd4, 1'b0, 1'b0);
      n_cmp++; if (bus.o_command !== CMD_PUSH) begin n_bad++; $display("FAIL filter_hi_cmd: got %0d expected %0d", bus.o_command, CMD_PUSH); end
      tick();
      n_cmp++; if (bus.o_cur_prio !== 3'd4) begin n_bad++; $display("FAIL filter_hi_prio: got %0d expected 4", bus.o_cur_prio); end
      n_cmp++; if (bus.o_depth !== 3'd2) begin n_bad++; $display("FAIL filter_hi_depth: got %0d expected 2", bus.o_depth); end
      drive(1'b0, 3'd0, 1'b0, 1'b0);
   endtask

   task automatic test_unwind();
      do_reset();
      drive(1'b1, 3'd2, 1'b0, 1'b0); tick();
      drive(1'b1, 3'd4, 1'b0, 1'b0); tick();
      drive(1'b0, 3'd0, 1'b1, 1'b0);
      n_cmp++; if (bus.o_command !== CMD_POP) begin n_bad++; $display("FAIL unwind_cmd0: got %0d expected %0d", bus.o_command, CMD_POP); end
      tick();
      n_cmp++; if (bus.o_cur_prio !== 3'd2) begin n_bad++; $display("FAIL unwind_prio0: got %0d expected 2", bus.o_cur_prio); end
      n_cmp++; if (bus.o_command !== CMD_POP) begin n_bad++; $display("FAIL unwind_cmd1: got %0d expected %0d", bus.o_command, CMD_POP); end
      tick();
      n_cmp++; if (bus.o_cur_prio !== 3'd0) begin n_bad++; $display("FAIL unwind_prio1: got %0d expected 0", bus.o_cur_prio); end
      n_cmp++; if (bus.o_error !== 1'b0) begin n_bad++; $display("FAIL unwind_err_early: got %0b expected 0", bus.o_error); end
      n_cmp++; if (bus.o_command !== CMD_NONE) begin n_bad++; $display("FAIL underflow_cmd: got %0d expected %0d", bus.o_command, CMD_NONE); end
      tick();
      n_cmp++; if (bus.o_depth !== 3'd0) begin n_bad++; $display("FAIL underflow_depth: got %0d expected 0", bus.o_depth); end
      n_cmp++; if (bus.o_error !== 1'b1) begin n_bad++; $display("FAIL underflow_err: got %0b expected 1", bus.o_error); end
      drive(1'b0, 3'd0, 1'b0, 1'b0);
      tick(); tick();
      n_cmp++; if (bus.o_error !== 1'b1) begin n_bad++; $display("FAIL error_sticky: got %0b expected 1", bus.o_error); end
      do_reset();
      n_cmp++; if (bus.o_error !== 1'b0) begin n_bad++; $display("FAIL error_clear: got %0b expected 0", bus.o_error); end
   endtask

   task automatic test_simul_ret_req();
      do_reset();
      drive(1'b1, 3'd2, 1'b0, 1'b0); tick();
      drive(1'b1, 3'd5, 1'b1, 1'b0);
`ifdef HIPPO_STACK_TAILCHAIN_EN
      n_cmp++; if (bus.o_command !== CMD_NONE) begin n_bad++; $display("FAIL chain_cmd: got %0d expected %0d", bus.o_command, CMD_NONE); end
      n_cmp++; if (bus.o_irq_ack !== 1'b1) begin n_bad++; $display("FAIL chain_ack: got %0b expected 1", bus.o_irq_ack); end
      tick();
      n_cmp++; if (bus.o_depth !== 3'd1) begin n_bad++; $display("FAIL chain_depth: got %0d expected 1", bus.o_depth); end
      n_cmp++; if (bus.o_cur_prio !== 3'd5) begin n_bad++; $display("FAIL chain_prio: got %0d expected 5", bus.o_cur_prio); end
`else
      n_cmp++; if (bus.o_command !== CMD_POP) begin n_bad++; $display("FAIL simul_cmd: got %0d expected %0d", bus.o_command, CMD_POP); end
      n_cmp++; if (bus.o_irq_ack !== 1'b0) begin n_bad++; $display("FAIL simul_ack: got %0b expected 0", bus.o_irq_ack); end
      tick();
      n_cmp++; if (bus.o_depth !== 3'd0) begin n_bad++; $display("FAIL simul_depth: got %0d expected 0", bus.o_depth); end
      n_cmp++; if (bus.o_cur_prio !== 3'd0) begin n_bad++; $display("FAIL simul_prio: got %0d expected 0", bus.o_cur_prio); end
`endif
      // Request not above the resumed context: plain pop in either build.
      do_reset();
      drive(1'b1, 3'd2, 1'b0, 1'b0); tick();
      drive(1'b1, 3'd5, 1'b0, 1'b0); tick();
      drive(1'b1, 3'd2, 1'b1, 1'b0);
      n_cmp++; if (bus.o_command !== CMD_POP) begin n_bad++; $display("FAIL lowreq_cmd: got %0d expected %0d", bus.o_command, CMD_POP); end
      n_cmp++; if (bus.o_irq_ack !== 1'b0) begin n_bad++; $display("FAIL lowreq_ack: got %0b expected 0", bus.o_irq_ack); end
      tick();
      n_cmp++; if (bus.o_cur_prio !== 3'd2) begin n_bad++; $display("FAIL lowreq_prio: got %0d expected 2", bus.o_cur_prio); end
      drive(1'b0, 3'd0, 1'b0, 1'b0);
   endtask

   task automatic test_stall();
      do_reset();
      drive(1'b1, 3'd3, 1'b0, 1'b0); tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 3'd7, 1'b1, 1'b1);
         n_cmp++; if (bus.o_command !== CMD_NONE) begin n_bad++; $display("FAIL stall_cmd[%0d]: got %0d expected %0d", k, bus.o_command, CMD_NONE); end
         n_cmp++; if (bus.o_irq_ack !== 1'b0) begin n_bad++; $display("FAIL stall_ack[%0d]: got %0b expected 0", k, bus.o_irq_ack); end
         tick();
         n_cmp++; if (bus.o_depth !== 3'd1) begin n_bad++; $display("FAIL stall_depth[%0d]: got %0d expected 1", k, bus.o_depth); end
         n_cmp++; if (bus.o_cur_prio !== 3'd3) begin n_bad++; $display("FAIL stall_prio[%0d]: got %0d expected 3", k, bus.o_cur_prio); end
      end
      // Stalled mret at depth 0 must not flag an error.
      do_reset();
      drive(1'b0, 3'd0, 1'b1, 1'b1); tick();
      n_cmp++; if (bus.o_error !== 1'b0) begin n_bad++; $display("FAIL stall_err: got %0b expected 0", bus.o_error); end
      drive(1'b0, 3'd0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1'b1, 3'd4, 1'b0, 1'b0);
      n_cmp++; if (bus.o_command !== CMD_PUSH) begin n_bad++; $display("FAIL b2b_push0: got %0d expected %0d", bus.o_command, CMD_PUSH); end
      tick();
      drive(1'b0, 3'd0, 1'b1, 1'b0);
      n_cmp++; if (bus.o_command !== CMD_POP) begin n_bad++; $display("FAIL b2b_pop: got %0d expected %0d", bus.o_command, CMD_POP); end
      tick();
      drive(1'b1, 3'd6, 1'b0, 1'b0);
      n_cmp++; if (bus.o_command !== CMD_PUSH) begin n_bad++; $display("FAIL b2b_push1: got %0d expected %0d", bus.o_command, CMD_PUSH); end
      tick();
      n_cmp++; if (bus.o_cur_prio !== 3'd6) begin n_bad++; $display("FAIL b2b_prio: got %0d expected 6", bus.o_cur_prio); end
      n_cmp++; if (bus.o_depth !== 3'd1) begin n_bad++; $display("FAIL b2b_depth: got %0d expected 1", bus.o_depth); end
      drive(1'b0, 3'd0, 1'b0, 1'b0);
      // Reset mid-nesting drops all contexts and blocks the pending push.
      drive(1'b1, 3'd7, 1'b0, 1'b0);
      i_reset = 1'b1;
      #1;
      n_cmp++; if (bus.o_command !== CMD_NONE) begin n_bad++; $display("FAIL midreset_cmd: got %0d expected %0d", bus.o_command, CMD_NONE); end
      tick();
      i_reset = 1'b0;
      drive(1'b0, 3'd0, 1'b0, 1'b0);
      n_cmp++; if (bus.o_depth !== 3'd0) begin n_bad++; $display("FAIL midreset_depth: got %0d expected 0", bus.o_depth); end
   endtask

   initial begin
      i_reset = 1'b1;
      drive(1'b0, 3'd0, 1'b0, 1'b0);
      test_reset();
      test_nest_full();
      test_prio_filter();
      test_unwind();
      test_simul_ret_req();
      test_stall();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/regfile_stack_ctx_ctrl.md
# regfile_stack_ctx_ctrl

Context-switch sequencer that drives the `Command` input of `veryl_stacked_regfile_RegFileStack`. It decides, cycle by cycle, when to issue `Command_push` on interrupt entry and `Command_pop` on interrupt return. It also keeps a priority stack that mirrors the register-file context stack, so nested preemption is legal and never overruns the stack. It sits between the interrupt arbiter/CSR unit and the stacked register file in the Hippomenes core.

## Interface
- `DEPTH`, default 4: number of interrupt contexts above the base (thread) context; must equal the stacked regfile's extra levels.
- `PRIO_W`, default 3: width of interrupt priority; priority 0 is the thread level and is never accepted as an interrupt.
- `i_clk`  in  1  clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_irq_valid`  in  1  highest-priority pending interrupt request from the arbiter.
- `i_irq_prio`  in  PRIO_W  priority of that request.
- `i_mret`  in  1  return-from-interrupt retiring this cycle.
- `i_stall`  in  1  pipeline stall; no context change is allowed while high.
- `o_command`  out  Command  command to the regfile stack (`Command_none`/`Command_push`/`Command_pop`), combinational.
- `o_irq_ack`  out  1  interrupt accepted this cycle, combinational.
- `o_depth`  out  $clog2(DEPTH+1)  current nesting depth (registered).
- `o_cur_prio`  out  PRIO_W  priority of the running context (registered; 0 at depth 0).
- `o_error`  out  1  sticky flag: `i_mret` seen at depth 0 (registered).

## Operation
- State: `depth` counter, priority stack `prio[0..DEPTH-1]`, `error` flag. `cur_prio` = `prio[depth-1]` when depth > 0, otherwise 0.
- `accept` = `i_irq_valid && !i_stall && i_irq_prio > cur_prio && depth < DEPTH`.
- `ret` = `i_mret && !i_stall && depth > 0`.
- Priority of decisions each cycle, evaluated in this order:
  1. Tail-chain case, only when configured (see Configuration).
  2. `ret`: `o_command = Command_pop`, depth decrements, `o_irq_ack = 0` even if `accept` also holds.
  3. `accept` (with `i_mret` low): `o_command = Command_push`, `o_irq_ack = 1`, `prio[depth] <= i_irq_prio`, depth increments.
  4. Otherwise `o_command = Command_none`, `o_irq_ack = 0`.
- `i_mret && !i_stall && depth == 0`: no command, depth stays 0, `error <= 1`.
- Equal or lower priority request: not acked; the request stays pending at the arbiter.
- At depth == DEPTH, requests are never acked, whatever their priority.
- At most one push or one pop per cycle. Depth never leaves `[0, DEPTH]`.

## Timing
- `o_command` and `o_irq_ack` are combinational from inputs and state. The regfile and this block both update on the same rising edge.
- `o_depth`, `o_cur_prio` and `o_error` reflect a decision on the cycle after it is made (1-cycle latency).
- Back-to-back push/pop on consecutive cycles is legal; there are no bubbles.
- Reset, sampled on a rising edge with `i_reset = 1`: depth 0, all `prio` entries 0, error 0. For that cycle `o_command = Command_none` and `o_irq_ack = 0` regardless of other inputs.
- Reset mid-nesting discards all contexts; the regfile is reset by the same signal.
- While `i_stall = 1`: `o_command = Command_none`, `o_irq_ack = 0`, no state change except `error` (not set either).

## Configuration
- `HIPPO_STACK_TAILCHAIN_EN`
- Defined: tail-chaining is enabled.
  - Trigger: `i_mret && i_irq_valid && !i_stall && depth > 0 && i_irq_prio > below`, where `below` = `prio[depth-2]`, or 0 when depth == 1.
  - Response: `o_command = Command_none`, `o_irq_ack = 1`, `prio[depth-1] <= i_irq_prio`, depth unchanged.
  - The interrupted context stays saved and the top-context registers are reused.
- Undefined: the tail-chain rule is absent. `i_mret` always pops and a simultaneous request is not acked that cycle.

## Test plan
- Reset: hold `i_reset` 1 cycle with `i_irq_valid = 1`, prio 5 -> `o_command = Command_none`, ack 0, depth 0, cur_prio 0, error 0.
- Nesting to full (DEPTH = 4): requests with prio 2, 3, 4, 5, 6 on consecutive cycles.
  - First four cycles: `Command_push` + ack each; depth 1..4, cur_prio 2..5.
  - Fifth cycle (prio 6): no ack, `Command_none`, depth stays 4.
- Priority filter: at depth 1 with cur_prio 3, request prio 3 -> no ack. Then prio 4 -> push, cur_prio 4.
- Unwind and underflow: from depth 2 (prio 2, 4), `i_mret` three cycles.
  - First two cycles: `Command_pop` each; cur_prio 2 then 0.
  - Third cycle: `Command_none`, error 1 and stays set until reset.
- Simultaneous return and request: depth 1, cur_prio 2, `i_mret` plus request prio 5.
  - Macro undefined: `Command_pop`, ack 0, depth 0.
  - Macro defined: `Command_none`, ack 1, depth 1, cur_prio 5.
- Stall: depth 1, `i_stall = 1` with both `i_mret` and a request prio 7 -> `Command_none`, ack 0, depth and cur_prio unchanged for the whole stall.
